// File: rtl/addsub_nibble_seq_pkg.sv
// Shared ALU definitions for the nibble-serial adder/subtractor: slice width,
// sequencer states, the flag bundle and the signed-overflow rule.
package addsub_nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } flags_t;

    // Two operands of equal sign producing a result of the other sign.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_nibble_seq_adder_283.sv
// 4-bit binary full adder with carry in/out, modelling one 74x283 slice.
module adder_283
    import addsub_nibble_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
    assign o_sum   = w_total[NIBBLE_W-1:0];
    assign o_cout  = w_total[NIBBLE_W];

endmodule

// File: rtl/addsub_nibble_seq.sv
// Multi-cycle W-bit adder/subtractor, one nibble per clock through adder_283.
// Optional macro ADDSUB_CARRY_IN_EN adds a cin port used as the initial carry.
module addsub_nibble_seq
    import addsub_nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        sub,
`ifdef ADDSUB_CARRY_IN_EN
    input  logic                        cin,
`endif
    input  logic [NIBBLES*NIBBLE_W-1:0] a,
    input  logic [NIBBLES*NIBBLE_W-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLES*NIBBLE_W-1:0] result,
    output logic                        carry,
    output logic                        zero,
    output logic                        negative,
    output logic                        overflow
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             r_state;
    state_e             w_state_next;
    logic               w_accept;
    logic               w_cin0;
    logic               w_last;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic               r_cy;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       w_a_sh;
    logic [W-1:0]       w_b_sh;
    logic [NIBBLE_W-1:0] w_sum;
    logic               w_cout;
    flags_t             w_flags;
    flags_t             r_flags;
    logic [W-1:0]       r_result;
    logic               r_busy;
    logic               r_done;

`ifdef ADDSUB_CARRY_IN_EN
    assign w_cin0 = cin;
`else
    assign w_cin0 = sub;
`endif

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_a_sh = r_a >> (r_idx * NIBBLE_W);
    assign w_b_sh = r_b >> (r_idx * NIBBLE_W);

    adder_283 u_adder (
        .i_a    (w_a_sh[NIBBLE_W-1:0]),
        .i_b    (w_b_sh[NIBBLE_W-1:0]),
        .i_cin  (r_cy),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sequencer next state; start is taken in IDLE and, back-to-back, in DONE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Flags are formed from the completed accumulator and the latched operands.
    always_comb begin
        w_flags          = '0;
        w_flags.carry    = r_cy;
        w_flags.zero     = (r_acc == {W{1'b0}});
        w_flags.negative = r_acc[W-1];
        w_flags.overflow = signed_overflow(r_a[W-1], r_b[W-1], r_acc[W-1]);
    end

    // State, operand latches, carry flip-flop and nibble accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_acc   <= {W{1'b0}};
            r_cy    <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b ^ {W{sub}};
                r_cy  <= w_cin0;
                r_idx <= {IDX_W{1'b0}};
            end else if (r_state == RUN) begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (r_idx == IDX_W'(n)) begin
                        r_acc[n*NIBBLE_W +: NIBBLE_W] <= w_sum;
                    end
                end
                r_cy  <= w_cout;
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Output registers lag the state by one edge, so only DONE publishes a result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {W{1'b0}};
            r_flags  <= '0;
        end else begin
            r_busy <= (r_state == RUN);
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_result <= r_acc;
                r_flags  <= w_flags;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign carry    = r_flags.carry;
    assign zero     = r_flags.zero;
    assign negative = r_flags.negative;
    assign overflow = r_flags.overflow;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed testbench for addsub_nibble_seq (default NIBBLES=2, 8-bit operands).
module tb_addsub_nibble_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    int n_checks;
    int n_fail;

    addsub_nibble_seq #(.NIBBLES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
`ifdef ADDSUB_CARRY_IN_EN
        .cin      (cin),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request; the edge that samples it is the next tick.
    task automatic drive(input logic [7:0] ia, input logic [7:0] ib,
                         input logic isub, input logic icin);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = isub;
        cin   = icin;
    endtask

    // Issue a request and advance to the cycle where done should be visible.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                         input logic isub, input logic icin);
        drive(ia, ib, isub, icin);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8'h3C, 8'h45, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_done got=%b exp=%b", {busy, done}, 2'b00);
        end
        n_checks++;
        if (result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_result got=%h exp=%h", result, 8'h00);
        end
        n_checks++;
        if ({carry, zero, negative, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=%b", {carry, zero, negative, overflow}, 4'b0000);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_start_ignored got=%b exp=%b", {busy, done}, 2'b00);
        end
    endtask

    task automatic test_add_latency();
        drive(8'h3C, 8'h45, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_t1_busy_done got=%b exp=%b", {busy, done}, 2'b10);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_t2_busy_done got=%b exp=%b", {busy, done}, 2'b10);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_t3_busy_done got=%b exp=%b", {busy, done}, 2'b01);
        end
        n_checks++;
        if (result !== 8'h81) begin
            n_fail++;
            $display("FAIL add_result got=%h exp=%h", result, 8'h81);
        end
        n_checks++;
        if ({carry, zero, negative, overflow} !== 4'b0011) begin
            n_fail++;
            $display("FAIL add_flags_czvn got=%b exp=%b", {carry, zero, negative, overflow}, 4'b0011);
        end
        tick();
        n_checks++;
        if ({busy, done, result} !== {2'b00, 8'h81}) begin
            n_fail++;
            $display("FAIL add_hold got=%b/%h exp=00/81", {busy, done}, result);
        end
    endtask

    task automatic test_sub_wrap();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vs [3];
        logic [7:0] er [3];
        logic [3:0] ef [3];
        va[0] = 8'h10; vb[0] = 8'h01; vs[0] = 1'b1; er[0] = 8'h0F; ef[0] = 4'b1000;
        va[1] = 8'h05; vb[1] = 8'h05; vs[1] = 1'b1; er[1] = 8'h00; ef[1] = 4'b1100;
        va[2] = 8'hFF; vb[2] = 8'h01; vs[2] = 1'b0; er[2] = 8'h00; ef[2] = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vs[i], vs[i]);
            n_checks++;
            if ({done, result} !== {1'b1, er[i]}) begin
                n_fail++;
                $display("FAIL subwrap%0d_result got=%b/%h exp=1/%h", i, done, result, er[i]);
            end
            n_checks++;
            if ({carry, zero, negative, overflow} !== ef[i]) begin
                n_fail++;
                $display("FAIL subwrap%0d_flags got=%b exp=%b", i, {carry, zero, negative, overflow}, ef[i]);
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        drive(8'h7F, 8'h7F, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if ({done, result} !== {1'b1, 8'h02}) begin
            n_fail++;
            $display("FAIL busy_ignore_result got=%b/%h exp=1/02", done, result);
        end
        n_checks++;
        if ({carry, zero, negative, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_ignore_flags got=%b exp=%b", {carry, zero, negative, overflow}, 4'b0000);
        end
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_ignore_no_second got=%b exp=%b", {busy, done}, 2'b00);
        end
    endtask

    task automatic test_mid_reset();
        drive(8'h3C, 8'h45, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, result} !== {2'b00, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%b/%h exp=00/00", {busy, done}, result);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_no_done%0d got=%b exp=%b", i, {busy, done}, 2'b00);
            end
        end
        n_checks++;
        if ({result, carry, zero, negative, overflow} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_result got=%h/%b exp=00/0000", result, {carry, zero, negative, overflow});
        end
    endtask

    task automatic test_back_to_back();
        drive(8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        drive(8'h80, 8'h01, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, result} !== {1'b1, 8'h03}) begin
            n_fail++;
            $display("FAIL b2b_first got=%b/%h exp=1/03", done, result);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_second_busy got=%b exp=%b", {busy, done}, 2'b10);
        end
        tick();
        tick();
        n_checks++;
        if ({done, result} !== {1'b1, 8'h7F}) begin
            n_fail++;
            $display("FAIL b2b_second got=%b/%h exp=1/7f", done, result);
        end
        n_checks++;
        if ({carry, zero, negative, overflow} !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_second_flags got=%b exp=%b", {carry, zero, negative, overflow}, 4'b1001);
        end
        tick();
    endtask

`ifdef ADDSUB_CARRY_IN_EN
    task automatic test_carry_in();
        do_op(8'h0F, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if ({done, result, carry} !== {1'b1, 8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL adc_result got=%b/%h/%b exp=1/10/0", done, result, carry);
        end
        tick();
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({done, result} !== {1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL sbc_result got=%b/%h exp=1/ff", done, result);
        end
        n_checks++;
        if ({carry, zero, negative, overflow} !== 4'b0010) begin
            n_fail++;
            $display("FAIL sbc_flags got=%b exp=%b", {carry, zero, negative, overflow}, 4'b0010);
        end
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        cin      = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        test_reset();
        test_add_latency();
        test_sub_wrap();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
`ifdef ADDSUB_CARRY_IN_EN
        test_carry_in();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
